gate_ctrl: RTL and testbench

- Control and readout end of the equal-precision frequency meter; drives EN/CLR of the 6-digit BCD event counter (clocked by F_IN) and reads back its digits.
- Opens and closes the actual gate on synchronized F_IN rising edges. Counts reference CLK cycles over exactly that gate, then latches counter digits, reference count and overflow for the display/divider stage (f_x = N_x * f_clk / N_REF).

---
 rtl/gate_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_gate_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_ctrl.sv
// Gate and readout controller for an equal-precision frequency meter: opens and closes
// the event-counter gate on synchronized F_IN edges and latches N_x, N_REF and overflow.
module gate_ctrl #(
    parameter int GATE_CYCLES = 50000000,
    parameter int REF_W       = 32,
    parameter int SETTLE      = 2,
    parameter int TIMEOUT     = 100000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             f_in,
    input  logic [3:0]       q0,
    input  logic [3:0]       q1,
    input  logic [3:0]       q2,
    input  logic [3:0]       q3,
    input  logic [3:0]       q4,
    input  logic [3:0]       q5,
    input  logic             f_ovf,
    output logic             en,
    output logic             clr,
    output logic [3:0]       d0,
    output logic [3:0]       d1,
    output logic [3:0]       d2,
    output logic [3:0]       d3,
    output logic [3:0]       d4,
    output logic [3:0]       d5,
    output logic [REF_W-1:0] n_ref,
    output logic             valid,
    output logic             ovf,
    output logic             no_sig
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam int ST_W = $clog2(SETTLE + 1);
    localparam logic [REF_W-1:0] GATE_LEN = REF_W'(GATE_CYCLES);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_ARM,
        S_GATE,
        S_SETTLE
    } state_t;

    state_t           state;
    logic [2:0]       fin_sync;
    logic [1:0]       ovf_sync;
    logic [REF_W-1:0] ref_cnt;
    logic [REF_W-1:0] timer;
    logic [WD_W-1:0]  wdog;
    logic [ST_W-1:0]  settle_cnt;
    logic             edge_seen;
    logic             ovf_flag;
    logic             fin_edge;
    logic             expired;
    logic             wd_fire;

    // fin_sync[1] is the synchronized F_IN; fin_sync[2] is its previous value.
    assign fin_edge = fin_sync[1] & ~fin_sync[2];
    assign expired  = (timer >= GATE_LEN);
    assign wd_fire  = (state != S_SETTLE) && !fin_edge && (wdog == WD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fin_sync <= '0;
            ovf_sync <= '0;
        end else begin
            // NOTE: non-blocking assignments make each stage take the previous stage's old value,
            // which is what turns this shift into a real multi-flop synchronizer.
            fin_sync <= {fin_sync[1:0], f_in};
            ovf_sync <= {ovf_sync[0], f_ovf};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_CLEAR;
            en         <= 1'b0;
            clr        <= 1'b1;
            d0         <= '0;
            d1         <= '0;
            d2         <= '0;
            d3         <= '0;
            d4         <= '0;
            d5         <= '0;
            n_ref      <= '0;
            valid      <= 1'b0;
            ovf        <= 1'b0;
            no_sig     <= 1'b0;
            ref_cnt    <= '0;
            timer      <= '0;
            wdog       <= '0;
            settle_cnt <= '0;
            edge_seen  <= 1'b0;
            ovf_flag   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (state != S_SETTLE) begin
                wdog <= fin_edge ? '0 : wdog + 1'b1;
            end

            if (wd_fire) begin
                // No F_IN edge for TIMEOUT cycles: publish an empty result flagged as no signal.
                state     <= S_CLEAR;
                en        <= 1'b0;
                clr       <= 1'b1;
                d0        <= '0;
                d1        <= '0;
                d2        <= '0;
                d3        <= '0;
                d4        <= '0;
                d5        <= '0;
                n_ref     <= '0;
                ovf       <= 1'b0;
                no_sig    <= 1'b1;
                valid     <= 1'b1;
                edge_seen <= 1'b0;
                wdog      <= '0;
            end else begin
                case (state)
                    S_CLEAR: begin
                        // CLR must be seen by the counter on two F_IN edges before arming.
                        if (fin_edge) begin
                            if (edge_seen) begin
                                state     <= S_ARM;
                                clr       <= 1'b0;
                                edge_seen <= 1'b0;
                            end else begin
                                edge_seen <= 1'b1;
                            end
                        end
                    end
                    S_ARM: begin
                        if (fin_edge) begin
                            state    <= S_GATE;
                            en       <= 1'b1;
                            ref_cnt  <= REF_W'(1);
                            timer    <= REF_W'(1);
                            ovf_flag <= 1'b0;
                        end
                    end
                    S_GATE: begin
                        ovf_flag <= ovf_flag | ovf_sync[1];
                        if (fin_edge && expired) begin
                            state      <= S_SETTLE;
                            en         <= 1'b0;
                            settle_cnt <= '0;
                        end else begin
                            ref_cnt <= (ref_cnt == '1) ? ref_cnt : ref_cnt + 1'b1;
                            if (!expired) begin
                                timer <= timer + 1'b1;
                            end
                        end
                    end
                    S_SETTLE: begin
                        // Digits are read only after the counter has had SETTLE cycles to ripple.
                        if (settle_cnt == ST_LAST) begin
                            d0        <= q0;
                            d1        <= q1;
                            d2        <= q2;
                            d3        <= q3;
                            d4        <= q4;
                            d5        <= q5;
                            n_ref     <= ref_cnt;
                            ovf       <= ovf_flag;
                            no_sig    <= 1'b0;
                            valid     <= 1'b1;
                            state     <= S_CLEAR;
                            clr       <= 1'b1;
                            edge_seen <= 1'b0;
                            wdog      <= '0;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                    default: state <= S_CLEAR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gate_ctrl.sv
// Bench for gate_ctrl: behavioural 6-digit BCD event counter in the F_IN domain,
// table-driven measurement vectors, scoreboard on VALID, and gate timing monitors.
`timescale 1ns/1ps
module tb_gate_ctrl;

    localparam int GATE_CYCLES = 100;
    localparam int REF_W       = 32;
    localparam int SETTLE      = 2;
    localparam int TIMEOUT     = 1000;
    localparam int CLK_NS      = 10;

    typedef struct packed {
        logic [23:0]      d;
        logic [REF_W-1:0] n_ref;
        logic             ovf;
        logic             no_sig;
    } result_t;

    typedef struct {
        int      period;
        int      n_meas;
        int      preload;
        bit      clr_off;
        result_t exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             f_in;
    logic [3:0]       q0, q1, q2, q3, q4, q5;
    logic             f_ovf;
    logic             en, clr, valid, ovf, no_sig;
    logic [3:0]       d0, d1, d2, d3, d4, d5;
    logic [REF_W-1:0] n_ref;
    logic [23:0]      d_bus;

    int  checks   = 0;
    int  failures = 0;
    int  period   = 0;
    int  preload  = 0;
    bit  clr_off  = 1'b0;
    int  cnt;
    result_t exp_q[$];

    gate_ctrl #(
        .GATE_CYCLES(GATE_CYCLES),
        .REF_W      (REF_W),
        .SETTLE     (SETTLE),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .f_in  (f_in),
        .q0    (q0),
        .q1    (q1),
        .q2    (q2),
        .q3    (q3),
        .q4    (q4),
        .q5    (q5),
        .f_ovf (f_ovf),
        .en    (en),
        .clr   (clr),
        .d0    (d0),
        .d1    (d1),
        .d2    (d2),
        .d3    (d3),
        .d4    (d4),
        .d5    (d5),
        .n_ref (n_ref),
        .valid (valid),
        .ovf   (ovf),
        .no_sig(no_sig)
    );

    always #(CLK_NS / 2) clk = ~clk;

    assign d_bus = {d5, d4, d3, d2, d1, d0};

    // Event counter: synchronous clear and count on F_IN, carry-out lasts one F_IN period.
    always @(posedge f_in or posedge rst) begin
        if (rst) begin
            cnt   <= preload;
            f_ovf <= 1'b0;
        end else if (clr && !clr_off) begin
            cnt   <= 0;
            f_ovf <= 1'b0;
        end else if (en) begin
            cnt   <= (cnt == 999999) ? 0 : cnt + 1;
            f_ovf <= (cnt == 999999);
        end
    end

    assign q0 = 4'(cnt % 10);
    assign q1 = 4'((cnt / 10) % 10);
    assign q2 = 4'((cnt / 100) % 10);
    assign q3 = 4'((cnt / 1000) % 10);
    assign q4 = 4'((cnt / 10000) % 10);
    assign q5 = 4'((cnt / 100000) % 10);

    // F_IN source, edges 3 ns after a CLK edge; period 0 holds it low.
    initial begin
        f_in = 1'b0;
        @(posedge clk);
        #3;
        forever begin
            if (period == 0) begin
                f_in = 1'b0;
                @(posedge clk);
                #3;
            end else begin
                int p;
                p = period;
                f_in = 1'b1;
                repeat (p / 2) @(posedge clk);
                #3;
                f_in = 1'b0;
                repeat (p - p / 2) @(posedge clk);
                #3;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Scoreboard and output-hold monitor.
    logic             prev_valid = 1'b0;
    logic [23:0]      prev_d     = '0;
    logic [REF_W-1:0] prev_nref  = '0;
    logic             prev_ovf   = 1'b0;
    logic             prev_nosig = 1'b0;

    always @(negedge clk) begin : sb_mon
        result_t e;
        if (valid) begin
            check("valid_one_cycle", prev_valid, 1'b0);
            check("valid_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("d", d_bus, e.d);
                check("n_ref", n_ref, e.n_ref);
                check("ovf", ovf, e.ovf);
                check("no_sig", no_sig, e.no_sig);
            end
        end else if (!rst) begin
            check("hold", {d_bus, n_ref, ovf, no_sig}, {prev_d, prev_nref, prev_ovf, prev_nosig});
        end
        prev_valid <= valid;
        prev_d     <= d_bus;
        prev_nref  <= n_ref;
        prev_ovf   <= ovf;
        prev_nosig <= no_sig;
    end

    // Gate timing: EN moves 2-3 CLK after an F_IN edge, CLR spans >=2 edges before each gate,
    // and the next edge after closing is further than SETTLE+3 CLK away.
    time  t_pos  = 0;
    time  t_rise = 0;
    time  t_fall = 0;
    int   clr_edges = 0;
    int   gate_base = 0;
    logic prev_en = 1'b0;
    bit   fall_pending = 1'b0;

    always @(posedge clk) t_pos <= $time;

    always @(posedge f_in) begin
        t_rise <= $time;
        if (!rst && clr) clr_edges <= clr_edges + 1;
    end

    always @(negedge clk) begin
        if (!rst && en !== prev_en) begin
            check("en_after_edge",
                  (t_pos - t_rise >= time'(2 * CLK_NS)) && (t_pos - t_rise <= time'(3 * CLK_NS)), 1'b1);
            if (en) begin
                check("clr_edges_before_gate", (clr_edges - gate_base) >= 2, 1'b1);
                gate_base <= clr_edges;
            end else begin
                fall_pending <= 1'b1;
                t_fall       <= t_pos;
            end
        end
        if (fall_pending && t_rise > t_fall) begin
            check("settle_gap", (t_rise - t_fall) > time'((SETTLE + 3) * CLK_NS), 1'b1);
            fall_pending <= 1'b0;
        end
        if (rst) fall_pending <= 1'b0;
        prev_en <= en;
    end

    task automatic do_reset(input int pre, input bit coff);
        @(negedge clk);
        #2;
        preload = pre;
        clr_off = coff;
        rst     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic stop_fin();
        period = 0;
        repeat (30) @(posedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        vec_t    vecs[4];
        result_t r10;
        int      n;
        logic    got;

        vecs[0] = '{10, 3, 0,      1'b0, '{24'h000010, 32'd100, 1'b0, 1'b0}};
        vecs[1] = '{13, 3, 0,      1'b0, '{24'h000008, 32'd104, 1'b0, 1'b0}};
        vecs[2] = '{8,  2, 0,      1'b0, '{24'h000013, 32'd104, 1'b0, 1'b0}};
        vecs[3] = '{10, 1, 999995, 1'b1, '{24'h000005, 32'd100, 1'b1, 1'b0}};
        r10     = '{24'h000010, 32'd100, 1'b0, 1'b0};

        rst = 1'b0;
        #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_en", en, 1'b0);
        check("rst_clr", clr, 1'b1);
        check("rst_d", d_bus, 24'h0);
        check("rst_n_ref", n_ref, 0);
        check("rst_valid", valid, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_no_sig", no_sig, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            do_reset(vecs[i].preload, vecs[i].clr_off);
            for (int m = 0; m < vecs[i].n_meas; m++) exp_q.push_back(vecs[i].exp);
            period = vecs[i].period;
            drain(600 * vecs[i].n_meas);
            stop_fin();
        end

        // No signal from reset, then a signal appears.
        do_reset(0, 1'b0);
        exp_q.push_back('{24'h000000, 32'd0, 1'b0, 1'b1});
        n   = 0;
        got = 1'b0;
        while (!got && n < TIMEOUT + 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            got = valid;
        end
        check("timeout_latency", (n >= TIMEOUT - 1) && (n <= TIMEOUT + 1), 1'b1);
        exp_q.push_back(r10);
        period = 10;
        repeat (50) @(negedge clk);
        check("no_sig_held", no_sig, 1'b1);
        drain(1000);
        stop_fin();

        // Reset in the middle of a gate.
        do_reset(0, 1'b0);
        exp_q.push_back(r10);
        period = 10;
        drain(1000);
        n = 0;
        while (!en && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("gate_reopen", en, 1'b1);
        repeat (49) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_en", en, 1'b0);
        check("midrst_clr", clr, 1'b1);
        check("midrst_d", d_bus, 24'h0);
        check("midrst_n_ref", n_ref, 0);
        check("midrst_valid", valid, 1'b0);
        check("midrst_ovf", ovf, 1'b0);
        check("midrst_no_sig", no_sig, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        exp_q.push_back(r10);
        drain(1000);
        stop_fin();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
